// File: rtl/riscv_pkg.sv
// Shared types for the 5-stage RISC-V core: result-select encoding, forwarding
// selects and hazard-controller FSM states.
package riscv_pkg;

   localparam logic [1:0] RESULT_LOAD = 2'b01;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      MEM_ERR  = 2'b10
   } hctrl_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX-stage forwarding select for one source operand; MEM result beats WB result.
module fwd_sel
   import riscv_pkg::*;
(
   input  logic [4:0] i_rs,
   input  logic [4:0] i_rd_m,
   input  logic       i_reg_write_m,
   input  logic [4:0] i_rd_w,
   input  logic       i_reg_write_w,
   output fwd_sel_t   o_sel
);

   logic w_hit_m;
   logic w_hit_w;

   assign w_hit_m = i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs);
   assign w_hit_w = i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs);

   always_comb begin
      o_sel = FWD_RF;
      if (w_hit_m)
         o_sel = FWD_M;
      else if (w_hit_w)
         o_sel = FWD_W;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/forward generation, data-memory wait
// sequencing with timeout, and saturating stall/redirect counters.
module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [1:0]       ResultSrcE,
   input  logic             PCSrcE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             DMemReqM,
   input  logic             DMemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] RedirectCount,
   output hctrl_state_t     DbgState
);

   localparam int              WCW   = $clog2(WAIT_LIMIT + 1);
   localparam logic [WCW-1:0]  LIMIT = WCW'(WAIT_LIMIT);

   hctrl_state_t     r_state;
   hctrl_state_t     w_state_nxt;
   logic [WCW-1:0]   r_wait_cnt;
   logic [WCW-1:0]   w_wait_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_redir_cnt;

   logic     w_mem_stall;
   logic     w_load_use;
   logic     w_hold_all;
   logic     w_redir_applied;
   fwd_sel_t w_fwd_a;
   fwd_sel_t w_fwd_b;

   // MEM_ERR already holds the whole pipe, so mem_stall is only meaningful outside it.
   assign w_mem_stall = DMemReqM && !DMemReadyM && (r_state != MEM_ERR);
   assign w_load_use  = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));
   assign w_hold_all  = (r_state == MEM_ERR) || w_mem_stall;

   fwd_sel u_fwd_a (
      .i_rs          (Rs1E),
      .i_rd_m        (RdM),
      .i_reg_write_m (RegWriteM),
      .i_rd_w        (RdW),
      .i_reg_write_w (RegWriteW),
      .o_sel         (w_fwd_a)
   );

   fwd_sel u_fwd_b (
      .i_rs          (Rs2E),
      .i_rd_m        (RdM),
      .i_reg_write_m (RegWriteM),
      .i_rd_w        (RdW),
      .i_reg_write_w (RegWriteW),
      .o_sel         (w_fwd_b)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_wait_nxt      = r_wait_cnt;
      StallF          = 1'b0;
      StallD          = 1'b0;
      StallE          = 1'b0;
      StallM          = 1'b0;
      FlushD          = 1'b0;
      FlushE          = 1'b0;
      FlushW          = 1'b0;
      w_redir_applied = 1'b0;

      case (r_state)
         RUN: begin
            if (w_mem_stall) begin
               w_state_nxt = MEM_WAIT;
               w_wait_nxt  = WCW'(1);
            end
         end
         MEM_WAIT: begin
            if (!w_mem_stall) begin
               w_state_nxt = RUN;
               w_wait_nxt  = '0;
            end else if (r_wait_cnt == LIMIT) begin
               w_state_nxt = MEM_ERR;
            end else begin
               w_wait_nxt = r_wait_cnt + WCW'(1);
            end
         end
         MEM_ERR: begin
            w_state_nxt = MEM_ERR;
         end
         default: begin
            w_state_nxt = RUN;
            w_wait_nxt  = '0;
         end
      endcase

      // Memory hold swallows redirect and load-use; the redirect replays once EX moves.
      if (w_hold_all) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD          = 1'b1;
         FlushE          = 1'b1;
         w_redir_applied = 1'b1;
      end else if (w_load_use) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_redir_cnt <= '0;
      end else begin
         if (StallF && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_redir_applied && (r_redir_cnt != {CNT_W{1'b1}}))
            r_redir_cnt <= r_redir_cnt + CNT_W'(1);
      end
   end

   assign ForwardAE     = w_fwd_a;
   assign ForwardBE     = w_fwd_b;
   assign MemErr        = (r_state == MEM_ERR);
   assign StallCount    = r_stall_cnt;
   assign RedirectCount = r_redir_cnt;
   assign DbgState      = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle model predicts every output and
// pushes it to a queue; the sample at the falling edge pops and compares.
module tb_hazard_ctrl;
  import riscv_pkg::*;

  localparam int WAIT_LIMIT = 16;
  localparam int W          = 96;

  logic clk;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, RegWriteM, RegWriteW, DMemReqM, DMemReadyM;

  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] StallCount, RedirectCount;
  hctrl_state_t DbgState;

  logic s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushW, s_MemErr;
  logic [1:0] s_ForwardAE, s_ForwardBE;
  logic [3:0] s_StallCount, s_RedirectCount;
  hctrl_state_t s_DbgState;

  hazard_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
    .StallCount(StallCount), .RedirectCount(RedirectCount), .DbgState(DbgState)
  );

  // Narrow-counter instance sharing all inputs, used to observe saturation.
  hazard_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
    .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
    .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushW(s_FlushW),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .MemErr(s_MemErr),
    .StallCount(s_StallCount), .RedirectCount(s_RedirectCount), .DbgState(s_DbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  logic [1:0]  m_state;
  int          m_wait;
  logic [31:0] m_sc, m_rc;
  logic [3:0]  m_sc4, m_rc4;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [W-1:0] model_expect();
    logic ms, lu, hold;
    logic [3:0] st;
    logic [2:0] fl;
    st = 4'b0000;
    fl = 3'b000;
    ms = (m_state != 2'd2) && DMemReqM && !DMemReadyM;
    lu = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    hold = (m_state == 2'd2) || ms;
    if (hold) begin
      st = 4'b1111; fl = 3'b001;
    end else if (PCSrcE) begin
      fl = 3'b110;
    end else if (lu) begin
      st = 4'b1100; fl = 3'b010;
    end
    return {m_state, (m_state == 2'd2), st, fl, fwd_model(Rs1E), fwd_model(Rs2E),
            m_sc, m_rc, m_sc4, m_rc4, 10'd0};
  endfunction

  task automatic model_step();
    logic ms, lu, sf, redir;
    ms = (m_state != 2'd2) && DMemReqM && !DMemReadyM;
    lu = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    sf = (m_state == 2'd2) || ms || (!PCSrcE && lu);
    redir = (m_state != 2'd2) && !ms && PCSrcE;
    if (sf && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    if (sf && m_sc4 != 4'hF) m_sc4 = m_sc4 + 1;
    if (redir && m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
    if (redir && m_rc4 != 4'hF) m_rc4 = m_rc4 + 1;
    case (m_state)
      2'd0: if (ms) begin m_state = 2'd1; m_wait = 1; end
      2'd1: begin
        if (!ms) begin m_state = 2'd0; m_wait = 0; end
        else if (m_wait == WAIT_LIMIT) m_state = 2'd2;
        else m_wait = m_wait + 1;
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_wait = 0; m_sc = 0; m_rc = 0; m_sc4 = 0; m_rc4 = 0;
  endtask

  // scoreboard: pop the prediction for this cycle and compare field by field
  task automatic compare_out();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check("state",     64'(DbgState),      64'(e[95:94]));
    check("MemErr",    64'(MemErr),        64'(e[93]));
    check("Stall_FDEM", 64'({StallF, StallD, StallE, StallM}), 64'(e[92:89]));
    check("Flush_DEW", 64'({FlushD, FlushE, FlushW}), 64'(e[88:86]));
    check("ForwardAE", 64'(ForwardAE),     64'(e[85:84]));
    check("ForwardBE", 64'(ForwardBE),     64'(e[83:82]));
    check("StallCount",    64'(StallCount),    64'(e[81:50]));
    check("RedirectCount", 64'(RedirectCount), 64'(e[49:18]));
    check("StallCount4",   64'(s_StallCount),  64'(e[17:14]));
    check("RedirectCount4", 64'(s_RedirectCount), 64'(e[13:10]));
  endtask

  // driver: inputs are already applied; predict, sample at negedge, advance model
  task automatic run_cycle();
    exp_q.push_back(model_expect());
    @(negedge clk);
    compare_out();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    DMemReqM = 0; DMemReadyM = 0;
  endtask

  initial begin
    drive_idle();
    model_reset();
    reset = 1'b1;
    #2;
    check("rst_MemErr",    64'(MemErr),        64'd0);
    check("rst_StallCount", 64'(StallCount),   64'd0);
    check("rst_RedirCount", 64'(RedirectCount), 64'd0);
    check("rst_state",     64'(DbgState),      64'(RUN));
    #10 reset = 1'b0;
    @(posedge clk); #1;
    run_cycle();

    // forwarding: MEM beats WB, x0 never forwards
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    run_cycle();
    RdM = 0;
    run_cycle();
    Rs2E = 0; RdM = 0; RdW = 0;
    run_cycle();
    drive_idle();

    // load-use: one bubble, then the load has moved on
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    run_cycle();
    drive_idle();
    run_cycle();

    // redirect wins over load-use
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1;
    run_cycle();
    drive_idle();
    run_cycle();

    // memory wait: three not-ready cycles then ready, redirect held throughout
    DMemReqM = 1; DMemReadyM = 0; PCSrcE = 1;
    repeat (3) run_cycle();
    DMemReadyM = 1;
    run_cycle();
    drive_idle();
    run_cycle();

    // random traffic with small register numbers to force collisions
    for (int i = 0; i < 300; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE    = ($urandom_range(0, 3) == 0);
      RegWriteM = $urandom_range(0, 1); RegWriteW = $urandom_range(0, 1);
      DMemReqM   = ($urandom_range(0, 2) == 0);
      DMemReadyM = ($urandom_range(0, 2) != 0);
      run_cycle();
    end
    drive_idle();
    run_cycle();

    // timeout: WAIT_LIMIT+1 not-ready cycles, then MEM_ERR stays sticky
    DMemReqM = 1; DMemReadyM = 0;
    repeat (WAIT_LIMIT + 1) run_cycle();
    PCSrcE = 1;
    repeat (4) run_cycle();
    drive_idle();
    repeat (4) run_cycle();
    check("timeout_MemErr", 64'(MemErr), 64'd1);
    check("sat_StallCount4", 64'(s_StallCount), 64'hF);

    // asynchronous reset in the middle of a cycle
    #3 reset = 1'b1;
    #1;
    check("async_MemErr",     64'(MemErr),        64'd0);
    check("async_StallCount", 64'(StallCount),    64'd0);
    check("async_RedirCount", 64'(RedirectCount), 64'd0);
    check("async_state",      64'(DbgState),      64'(RUN));
    check("async_StallCount4", 64'(s_StallCount), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    run_cycle();
    DMemReqM = 1; DMemReadyM = 0;
    repeat (2) run_cycle();
    drive_idle();
    repeat (2) run_cycle();

    if (exp_q.size() != 0) check("exp_q_leftover", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
